// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer
//   Produces pixel_color for the DE0 VGA driver from the driver's raster position and blanking
//   flags. Debounced buttons step a pending pattern (next/prev) or toggle auto-cycling. The
//   pending pattern is committed to `mode` only on a V_blank rising edge, so a frame is never
//   torn. In auto mode the pattern advances every AUTO_FRAMES frames.
// Ports
//   clk_50, rst_n        : 50 MHz clock, asynchronous active-low reset
//   pixel_en             : one-cycle pixel strobe from the driver
//   X_pix, Y_pix         : current column / line (0-based)
//   H_blank, V_blank     : blanking flags
//   INPUT_BTN[2:0]       : raw active-low buttons: [0] next, [1] prev, [2] auto toggle
//   INPUT_SWS[9:0]       : raw switches
//   pixel_color[11:0]    : {R,G,B} nibbles, registered, valid the cycle after pixel_en
//   mode[2:0]            : committed pattern
//   auto_on              : auto-cycle enabled
//   frame_cnt[15:0]      : frame boundaries seen since reset (wraps)
module vga_pattern_sequencer #(
  parameter int unsigned H_ACTIVE        = 1280,
  parameter int unsigned V_ACTIVE        = 1024,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned AUTO_FRAMES     = 120,
  parameter int unsigned NUM_MODES       = 5
) (
  input  logic        clk_50,
  input  logic        rst_n,
  input  logic        pixel_en,
  input  logic [10:0] X_pix,
  input  logic [10:0] Y_pix,
  input  logic        H_blank,
  input  logic        V_blank,
  input  logic [2:0]  INPUT_BTN,
  input  logic [9:0]  INPUT_SWS,
  output logic [11:0] pixel_color,
  output logic [2:0]  mode,
  output logic        auto_on,
  output logic [15:0] frame_cnt
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned AfW = $clog2(AUTO_FRAMES + 1);
  localparam logic [DbW-1:0] DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AfW-1:0] AfLast   = AfW'(AUTO_FRAMES - 1);
  localparam logic [2:0]     ModeLast = 3'(NUM_MODES - 1);

  localparam logic [11:0] HAct = 12'(H_ACTIVE);
  localparam logic [11:0] VAct = 12'(V_ACTIVE);
  // Band edges; the last band absorbs the division remainder.
  localparam logic [11:0] HB1 = 12'(1 * (H_ACTIVE / 5));
  localparam logic [11:0] HB2 = 12'(2 * (H_ACTIVE / 5));
  localparam logic [11:0] HB3 = 12'(3 * (H_ACTIVE / 5));
  localparam logic [11:0] HB4 = 12'(4 * (H_ACTIVE / 5));
  localparam logic [11:0] VB1 = 12'(1 * (V_ACTIVE / 5));
  localparam logic [11:0] VB2 = 12'(2 * (V_ACTIVE / 5));
  localparam logic [11:0] VB3 = 12'(3 * (V_ACTIVE / 5));
  localparam logic [11:0] VB4 = 12'(4 * (V_ACTIVE / 5));

  function automatic logic [2:0] mode_inc(input logic [2:0] m);
    return (m >= ModeLast) ? 3'd0 : m + 3'd1;
  endfunction

  function automatic logic [2:0] mode_dec(input logic [2:0] m);
    return ((m == 3'd0) || (m > ModeLast)) ? ModeLast : m - 3'd1;
  endfunction

  function automatic logic [11:0] band_color(input logic [11:0] p, input logic [11:0] b1,
                                             input logic [11:0] b2, input logic [11:0] b3,
                                             input logic [11:0] b4);
    if (p < b1)      return 12'hFFF;
    else if (p < b2) return 12'h000;
    else if (p < b3) return 12'h00F;
    else if (p < b4) return 12'h0F0;
    else             return 12'hF00;
  endfunction

  // Input synchronizers
  logic [2:0] btn_s1_q, btn_s2_q;
  logic [9:0] sws_s1_q, sws_s2_q;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q <= 3'b111;
      btn_s2_q <= 3'b111;
      sws_s1_q <= '0;
      sws_s2_q <= '0;
    end else begin
      btn_s1_q <= INPUT_BTN;
      btn_s2_q <= btn_s1_q;
      sws_s1_q <= INPUT_SWS;
      sws_s2_q <= sws_s1_q;
    end
  end

  // Debouncers: the debounced level follows the synchronized input only after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles; press is the falling transition.
  logic [2:0]     db_q, db_d;
  logic [2:0]     press_q, press_d;
  logic [DbW-1:0] db_cnt_q [3];
  logic [DbW-1:0] db_cnt_d [3];

  always_comb begin
    db_d    = db_q;
    press_d = '0;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (btn_s2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          db_d[i]    = btn_s2_q[i];
          press_d[i] = ~btn_s2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      db_q     <= 3'b111;
      press_q  <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      db_q     <= db_d;
      press_q  <= press_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Mode control
  logic           vblank_q;
  logic [2:0]     pending_q, pending_d;
  logic [2:0]     mode_q, mode_d;
  logic           auto_on_q, auto_on_d;
  logic [AfW-1:0] auto_cnt_q, auto_cnt_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic           boundary, auto_adv, press_next, press_prev, manual;

  assign boundary   = V_blank & ~vblank_q;
  assign press_next = press_q[0] & ~press_q[1];
  assign press_prev = press_q[1] & ~press_q[0];
  assign manual     = press_q[0] | press_q[1];

  always_comb begin
    pending_d   = pending_q;
    mode_d      = mode_q;
    auto_on_d   = auto_on_q;
    auto_cnt_d  = auto_cnt_q;
    frame_cnt_d = frame_cnt_q;
    auto_adv    = 1'b0;

    if (boundary) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      if (auto_on_q) begin
        if (auto_cnt_q == AfLast) begin
          auto_cnt_d = '0;
          auto_adv   = 1'b1;
        end else begin
          auto_cnt_d = auto_cnt_q + AfW'(1);
        end
      end
    end

    // A manual step wins over an auto advance on the same boundary.
    if (press_next)      pending_d = mode_inc(pending_q);
    else if (press_prev) pending_d = mode_dec(pending_q);
    else if (auto_adv)   pending_d = mode_inc(pending_q);

    if (manual || press_q[2]) auto_cnt_d = '0;
    if (press_q[2])           auto_on_d  = ~auto_on_q;

    // Commit includes any change made on this same cycle.
    if (boundary) mode_d = pending_d;
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      vblank_q    <= 1'b0;
      pending_q   <= '0;
      mode_q      <= '0;
      auto_on_q   <= 1'b0;
      auto_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      vblank_q    <= V_blank;
      pending_q   <= pending_d;
      mode_q      <= mode_d;
      auto_on_q   <= auto_on_d;
      auto_cnt_q  <= auto_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Pattern generation
  logic [11:0] color_q, color_d;
  logic        active;
  logic [3:0]  chk_k;

  assign active = ~H_blank & ~V_blank & ({1'b0, X_pix} < HAct) & ({1'b0, Y_pix} < VAct);
  assign chk_k  = 4'd3 + {2'b00, sws_s2_q[1:0]};

  always_comb begin
    color_d = color_q;
    if (pixel_en) begin
      if (!active) begin
        color_d = 12'h000;
      end else begin
        case (mode_q)
          3'd0:    color_d = 12'hFFF;
          3'd1:    color_d = {2'b00, sws_s2_q};
          3'd2:    color_d = band_color({1'b0, Y_pix}, VB1, VB2, VB3, VB4);
          3'd3:    color_d = band_color({1'b0, X_pix}, HB1, HB2, HB3, HB4);
          3'd4:    color_d = (X_pix[chk_k] ^ Y_pix[chk_k]) ? 12'hFFF : 12'h000;
          default: color_d = 12'h000;
        endcase
      end
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) color_q <= '0;
    else        color_q <= color_d;
  end

  assign pixel_color = color_q;
  assign mode        = mode_q;
  assign auto_on     = auto_on_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
